// File: rtl/r_unit_pipe_if.sv
// r_unit_pipe_if: bundles the flit handshake, route, status and error-clear
// signals of one router input port. The master side (upstream/test driver)
// drives flits, out_ready and err_clr; the slave side (r_unit_pipe) drives
// in_ready, the registered flit/route, packet count and error flag.
interface r_unit_pipe_if #(
  parameter int FLIT_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] in_flit;
  logic              out_valid;
  logic              out_ready;
  logic [FLIT_W-1:0] out_flit;
  logic [8:0]        out_route;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              err_proto;
  logic              err_clr;

  modport master (
    output in_valid, in_flit, out_ready, err_clr,
    input  in_ready, out_valid, out_flit, out_route, pkt_cnt, err_proto
  );

  modport slave (
    input  in_valid, in_flit, out_ready, err_clr,
    output in_ready, out_valid, out_flit, out_route, pkt_cnt, err_proto
  );
endinterface

// File: rtl/r_unit_pipe.sv
// r_unit_pipe: registered, wormhole-aware route unit for one router input port.
// The head flit's destination is compared with this router's coordinates, the
// resulting one-hot direction is locked for the rest of the packet, and each
// accepted flit is presented one cycle later together with its route.
// Optional feature: define R_UNIT_DIAG_ROUTING_EN to select diagonal outputs
// (NE/NW/SE/SW) when both coordinates differ; otherwise XY dimension-order
// routing is used and out_route[8:5] stay 0.
module r_unit_pipe #(
  parameter int X_COORD   = 0,
  parameter int Y_COORD   = 0,
  parameter int MESH_SIDE = 4,
  parameter int FLIT_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  r_unit_pipe_if.slave bus
);

  localparam int COORD_W = $clog2(MESH_SIDE);
  localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_COORD);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_COORD);
  // One extra bit so a non-power-of-two side can be compared against.
  localparam logic [COORD_W:0]   SIDE = (COORD_W + 1)'(MESH_SIDE);

  // One-hot route bit positions.
  localparam int R_LOCAL = 0;
  localparam int R_N     = 1;
  localparam int R_E     = 2;
  localparam int R_S     = 3;
  localparam int R_W     = 4;
`ifdef R_UNIT_DIAG_ROUTING_EN
  localparam int R_NE    = 5;
  localparam int R_NW    = 6;
  localparam int R_SE    = 7;
  localparam int R_SW    = 8;
`endif

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic [8:0]        out_route_q, out_route_d;
  logic [8:0]        held_route_q, held_route_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;

  logic [1:0]         flit_type;
  logic               is_head;
  logic               is_tail;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  logic               dest_bad;
  logic               go_n, go_s, go_e, go_w;
  logic [8:0]         head_route;
  logic               accept;
  logic               pkt_done;
  logic               err_set;

  // Type field: bit1 marks a head, bit0 marks a tail (11 = single-flit packet).
  assign flit_type = bus.in_flit[FLIT_W-1 -: 2];
  assign is_head   = flit_type[1];
  assign is_tail   = flit_type[0];
  assign dest_x    = bus.in_flit[COORD_W-1:0];
  assign dest_y    = bus.in_flit[2*COORD_W-1:COORD_W];

  assign dest_bad = ({1'b0, dest_x} >= SIDE) || ({1'b0, dest_y} >= SIDE);
  assign go_n     = dest_y > MY_Y;
  assign go_s     = dest_y < MY_Y;
  assign go_e     = dest_x > MY_X;
  assign go_w     = dest_x < MY_X;

  // A new flit may enter whenever the output register is empty or draining.
  assign accept = bus.in_valid && (!out_valid_q || bus.out_ready);

  // Direction for the flit currently on in_flit, assuming it is a head.
  always_comb begin
    head_route = '0;
    if (dest_bad) begin
      head_route[R_LOCAL] = 1'b1;
    end else begin
`ifdef R_UNIT_DIAG_ROUTING_EN
      if (go_n && go_e)      head_route[R_NE]    = 1'b1;
      else if (go_n && go_w) head_route[R_NW]    = 1'b1;
      else if (go_s && go_e) head_route[R_SE]    = 1'b1;
      else if (go_s && go_w) head_route[R_SW]    = 1'b1;
      else if (go_n)         head_route[R_N]     = 1'b1;
      else if (go_s)         head_route[R_S]     = 1'b1;
      else if (go_e)         head_route[R_E]     = 1'b1;
      else if (go_w)         head_route[R_W]     = 1'b1;
      else                   head_route[R_LOCAL] = 1'b1;
`else
      if (go_e)      head_route[R_E]     = 1'b1;
      else if (go_w) head_route[R_W]     = 1'b1;
      else if (go_n) head_route[R_N]     = 1'b1;
      else if (go_s) head_route[R_S]     = 1'b1;
      else           head_route[R_LOCAL] = 1'b1;
`endif
    end
  end

  // Packet FSM, output register loading, packet counting and error detection.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    out_flit_d   = out_flit_q;
    out_route_d  = out_route_q;
    held_route_d = held_route_q;
    pkt_done     = 1'b0;
    err_set      = 1'b0;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (is_head) begin
            out_valid_d  = 1'b1;
            out_flit_d   = bus.in_flit;
            out_route_d  = head_route;
            held_route_d = head_route;
            err_set      = dest_bad;
            if (is_tail) pkt_done = 1'b1;
            else         state_d  = LOCKED;
          end else begin
            // Orphan body/tail: swallowed, flagged.
            err_set = 1'b1;
          end
        end
        LOCKED: begin
          out_valid_d = 1'b1;
          out_route_d = held_route_q;
          if (is_head) begin
            // Stray head inside a packet continues the worm as a body flit.
            out_flit_d = {2'b00, bus.in_flit[FLIT_W-3:0]};
            err_set    = 1'b1;
          end else begin
            out_flit_d = bus.in_flit;
            if (is_tail) begin
              pkt_done = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pkt_cnt_d = pkt_cnt_q;
    if (pkt_done && (pkt_cnt_q != {CNT_W{1'b1}})) pkt_cnt_d = pkt_cnt_q + 1'b1;

    // A new error wins over a clear requested in the same cycle.
    err_d = err_q;
    if (err_set)          err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
  end

  // State and output registers; reset drops any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_flit_q   <= '0;
      out_route_q  <= '0;
      held_route_q <= '0;
      pkt_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_flit_q   <= out_flit_d;
      out_route_q  <= out_route_d;
      held_route_q <= held_route_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_route = out_route_q;
  assign bus.pkt_cnt   = pkt_cnt_q;
  assign bus.err_proto = err_q;

endmodule

// File: tb/tb_r_unit_pipe.sv
// tb_r_unit_pipe: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a packet-level model.
module tb_r_unit_pipe;

  localparam int FW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r_unit_pipe_if #(.FLIT_W(FW), .CNT_W(16)) bus ();
  r_unit_pipe_if #(.FLIT_W(FW), .CNT_W(2))  bus2 ();

  r_unit_pipe #(.X_COORD(1), .Y_COORD(1), .MESH_SIDE(4), .FLIT_W(FW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  r_unit_pipe #(.X_COORD(1), .Y_COORD(1), .MESH_SIDE(4), .FLIT_W(FW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int n_checks = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int dx, input int dy,
                                       input logic [25:0] pl);
    logic [1:0] x2;
    logic [1:0] y2;
    x2 = dx[1:0];
    y2 = dy[1:0];
    return {t, pl, y2, x2};
  endfunction

  // Expected direction for a router at (1,1) in a 4x4 mesh.
  function automatic logic [8:0] ref_route(input int dx, input int dy);
    if (dx >= 4 || dy >= 4) return 9'h001;
`ifdef R_UNIT_DIAG_ROUTING_EN
    if (dx != 1 && dy != 1) begin
      if (dy > 1) return (dx > 1) ? 9'h020 : 9'h040;
      else        return (dx > 1) ? 9'h080 : 9'h100;
    end
`endif
    if (dx > 1) return 9'h004;
    if (dx < 1) return 9'h010;
    if (dy > 1) return 9'h002;
    if (dy < 1) return 9'h008;
    return 9'h001;
  endfunction

  // Behavioural model: one-entry output slot plus an "inside a packet" flag.
  logic          m_valid;
  logic [FW-1:0] m_flit;
  logic [8:0]    m_route;
  logic [8:0]    m_held;
  logic          m_in_pkt;
  logic [15:0]   m_cnt;
  logic          m_err;
  logic          t_acc, t_keep, t_set, t_done;
  logic [FW-1:0] t_flit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_flit   <= '0;
      m_route  <= '0;
      m_held   <= '0;
      m_in_pkt <= 1'b0;
      m_cnt    <= '0;
      m_err    <= 1'b0;
    end else begin
      t_flit = bus.in_flit;
      t_acc  = bus.in_valid && (!m_valid || bus.out_ready);
      t_keep = m_valid && !bus.out_ready;
      t_set  = 1'b0;
      t_done = 1'b0;
      if (t_acc) begin
        if (!m_in_pkt) begin
          if (t_flit[31]) begin
            m_flit  <= t_flit;
            m_route <= ref_route(int'(t_flit[1:0]), int'(t_flit[3:2]));
            m_held  <= ref_route(int'(t_flit[1:0]), int'(t_flit[3:2]));
            t_keep  = 1'b1;
            if (t_flit[30]) t_done = 1'b1;
            else            m_in_pkt <= 1'b1;
          end else begin
            t_set = 1'b1;
          end
        end else begin
          t_keep  = 1'b1;
          m_route <= m_held;
          if (t_flit[31]) begin
            m_flit <= {2'b00, t_flit[29:0]};
            t_set  = 1'b1;
          end else begin
            m_flit <= t_flit;
            if (t_flit[30]) begin
              t_done = 1'b1;
              m_in_pkt <= 1'b0;
            end
          end
        end
      end
      m_valid <= t_keep;
      if (t_done && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      if (t_set)            m_err <= 1'b1;
      else if (bus.err_clr) m_err <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("in_ready", 64'(bus.in_ready), 64'(!m_valid || bus.out_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_flit", 64'(bus.out_flit), 64'(m_flit));
        chk("out_route", 64'(bus.out_route), 64'(m_route));
        chk("route_onehot", 64'($onehot(bus.out_route)), 64'd1);
      end
      chk("pkt_cnt", 64'(bus.pkt_cnt), 64'(m_cnt));
      chk("err_proto", 64'(bus.err_proto), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.err_clr  = 1'b0;
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [FW-1:0] f_head, f_b1, f_b2, f_tail;
  logic [8:0]    exp_r;
  logic [1:0]    rt;
  int            sat_exp;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_flit   = '0;
    bus.out_ready = 1'b1;
    bus.err_clr   = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_flit  = '0;
    bus2.out_ready = 1'b1;
    bus2.err_clr  = 1'b0;
    do_reset();
    cmp_en = 1'b1;

    // Reset state.
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_flit", 64'(bus.out_flit), 64'd0);
    chk("rst_out_route", 64'(bus.out_route), 64'd0);
    chk("rst_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
    chk("rst_err", 64'(bus.err_proto), 64'd0);

    // Single-flit packet to (3,3).
`ifdef R_UNIT_DIAG_ROUTING_EN
    exp_r = 9'h020;
`else
    exp_r = 9'h004;
`endif
    bus.in_flit = mk(2'b11, 3, 3, 26'h0AB);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("ht33_valid", 64'(bus.out_valid), 64'd1);
    chk("ht33_route", 64'(bus.out_route), 64'(exp_r));
    chk("ht33_cnt", 64'(bus.pkt_cnt), 64'd1);
    tick();

    // Four-flit packet to (1,0) with a 3-cycle downstream stall.
    do_reset();
    f_head = mk(2'b10, 1, 0, 26'h111);
    f_b1   = mk(2'b00, 2, 2, 26'h222);
    f_b2   = mk(2'b00, 3, 1, 26'h333);
    f_tail = mk(2'b01, 0, 3, 26'h444);
    bus.in_valid = 1'b1;
    bus.in_flit = f_head;
    tick();
    chk("s_head_flit", 64'(bus.out_flit), 64'(f_head));
    chk("s_head_route", 64'(bus.out_route), 64'h008);
    bus.in_flit = f_b1;
    tick();
    chk("s_b1_flit", 64'(bus.out_flit), 64'(f_b1));
    bus.in_flit = f_b2;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flit", 64'(bus.out_flit), 64'(f_b1));
      chk("stall_route", 64'(bus.out_route), 64'h008);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("s_b2_flit", 64'(bus.out_flit), 64'(f_b2));
    chk("s_b2_route", 64'(bus.out_route), 64'h008);
    bus.in_flit = f_tail;
    tick();
    bus.in_valid = 1'b0;
    chk("s_tail_flit", 64'(bus.out_flit), 64'(f_tail));
    chk("s_tail_route", 64'(bus.out_route), 64'h008);
    chk("s_cnt", 64'(bus.pkt_cnt), 64'd1);
    tick();
    chk("s_drained", 64'(bus.out_valid), 64'd0);

    // Orphan body flit, then sticky error and its clear.
    do_reset();
    bus.in_flit = mk(2'b00, 2, 2, 26'h555);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("orphan_valid", 64'(bus.out_valid), 64'd0);
    chk("orphan_err", 64'(bus.err_proto), 64'd1);
    repeat (3) tick();
    chk("err_sticky", 64'(bus.err_proto), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_cleared", 64'(bus.err_proto), 64'd0);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    bus.in_flit = mk(2'b11, 0, 0, 26'h0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_flit = mk(2'b10, 0, 2, 26'h666);
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_cnt", 64'(bus.pkt_cnt), 64'd0);
    chk("async_rst_flit", 64'(bus.out_flit), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_flit = mk(2'b11, 1, 1, 26'h777);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("local_valid", 64'(bus.out_valid), 64'd1);
    chk("local_route", 64'(bus.out_route), 64'h001);
    chk("local_cnt", 64'(bus.pkt_cnt), 64'd1);
    tick();

    // Back-to-back single-flit packets to (2,1).
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_flit = mk(2'b11, 2, 1, 26'(i + 16));
      tick();
      chk("b2b_valid", 64'(bus.out_valid), 64'd1);
      chk("b2b_route", 64'(bus.out_route), 64'h004);
      chk("b2b_flit", 64'(bus.out_flit), 64'(mk(2'b11, 2, 1, 26'(i + 16))));
    end
    bus.in_valid = 1'b0;
    tick();

    // Saturating 2-bit packet counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus2.in_flit = mk(2'b11, 2, 1, 26'(i));
      bus2.in_valid = 1'b1;
      tick();
      bus2.in_valid = 1'b0;
      sat_exp = (i + 1 > 3) ? 3 : i + 1;
      chk("sat_cnt", 64'(bus2.pkt_cnt), 64'(sat_exp));
    end

    // Randomized traffic, checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.err_clr   = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5:          rt = 2'b10;
        6, 7, 8, 9, 10, 11, 12, 13: rt = 2'b00;
        14, 15, 16, 17, 18:        rt = 2'b01;
        default:                   rt = 2'b11;
      endcase
      bus.in_flit = mk(rt, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       26'($urandom));
      tick();
    end
    bus.in_valid = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
